// File: rtl/spi_cmd_tx_pkg.sv
// spi_cmd_tx_pkg: frame layout, command codes and FSM state shared by the SPI command link.
package spi_cmd_tx_pkg;
    localparam int FRAME_LEN = 53;
    localparam int WCMD = 8;
    localparam int WPAYLOAD = FRAME_LEN - WCMD;
    localparam int WCOLOR = 6;
    localparam int WPX = 7;
    localparam int WPY = 6;
    localparam int OFF_COLOR = 0;
    localparam int OFF_V0X = OFF_COLOR + WCOLOR;
    localparam int OFF_V1X = OFF_V0X + WPX;
    localparam int OFF_V2X = OFF_V1X + WPX;
    localparam int OFF_V0Y = OFF_V2X + WPX;
    localparam int OFF_V1Y = OFF_V0Y + WPY;
    localparam int OFF_V2Y = OFF_V1Y + WPY;
    localparam logic [WCMD-1:0] CMD_POLY_A = 8'h80;
    localparam logic [WCMD-1:0] CMD_POLY_B = 8'h81;
    localparam logic [WCMD-1:0] CMD_POLY_C = 8'h82;
    localparam logic [WCMD-1:0] CMD_CLR_A = 8'h40;
    localparam logic [WCMD-1:0] CMD_CLR_B = 8'h41;
    localparam logic [WCMD-1:0] CMD_CLR_C = 8'h42;
    localparam logic [WCMD-1:0] CMD_SET_BG = 8'h01;

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOW, S_HIGH, S_HOLD, S_GAP} state_e;

    function automatic int max_of(input int a, input int b);
        return a > b ? a : b;
    endfunction
endpackage

// File: rtl/spi_cmd_tx.sv
// spi_cmd_tx: SPI master that serialises one 53-bit command frame per handshake, LSB first.
module spi_cmd_tx
    import spi_cmd_tx_pkg::*;
#(
    parameter int HALF_DIV = 4,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD = 6,
    parameter int CS_GAP = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WCMD-1:0]     cmd_in,
    input  logic [WPAYLOAD-1:0] payload_in,
    input  logic                tx_valid,
    output logic                tx_ready,
    input  logic                tx_allow,
    output logic                busy,
    output logic                done,
    output logic                sck_out,
    output logic                cs_out,
    output logic                mosi_out
);
    localparam int DW = $clog2(max_of(max_of(HALF_DIV, CS_SETUP), max_of(CS_HOLD, CS_GAP))) + 1;
    localparam logic [DW-1:0] HALF_LAST = DW'(HALF_DIV - 1);
    localparam logic [DW-1:0] SETUP_LAST = DW'(CS_SETUP - 1);
    localparam logic [DW-1:0] HOLD_LAST = DW'(CS_HOLD - 1);
    localparam logic [DW-1:0] GAP_LAST = DW'(CS_GAP - 1);
    localparam logic [5:0] LAST_BIT = 6'(FRAME_LEN - 1);

    state_e                 state_q;
    logic [DW-1:0]          div_q;
    logic [DW-1:0]          div_lim;
    logic                   div_end;
    logic [5:0]             bit_q;
    logic [FRAME_LEN-2:0]   rest_q;
    logic                   ready_q, busy_q, done_q, sck_q, cs_q, mosi_q;

    assign div_lim = state_q == S_SETUP ? SETUP_LAST :
                     state_q == S_HOLD  ? HOLD_LAST  :
                     state_q == S_GAP   ? GAP_LAST   : HALF_LAST;
    assign div_end = div_q == div_lim;

    // rest_q holds the not-yet-sent bits; bit 0 is already on mosi when it is loaded
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            rest_q  <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sck_q   <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            div_q  <= div_end ? '0 : div_q + 1'b1;
            case (state_q)
                S_IDLE: begin
                    div_q <= '0;
                    if (tx_valid && ready_q) begin
                        rest_q  <= {payload_in, cmd_in[WCMD-1:1]};
                        mosi_q  <= cmd_in[0];
                        bit_q   <= '0;
                        cs_q    <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: if (div_end) state_q <= S_LOW;
                S_LOW: if (div_end) begin
                    if (tx_allow) begin
                        sck_q   <= 1'b1;
                        state_q <= S_HIGH;
                    end else begin
                        div_q <= div_q;
                    end
                end
                S_HIGH: if (div_end) begin
                    sck_q <= 1'b0;
                    if (bit_q == LAST_BIT) begin
                        state_q <= S_HOLD;
                    end else begin
                        bit_q   <= bit_q + 1'b1;
                        mosi_q  <= rest_q[0];
                        rest_q  <= rest_q >> 1;
                        state_q <= S_LOW;
                    end
                end
                S_HOLD: if (div_end) begin
                    cs_q    <= 1'b1;
                    done_q  <= 1'b1;
                    state_q <= S_GAP;
                end
                S_GAP: if (div_end) begin
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx_ready = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign sck_out  = sck_q;
    assign cs_out   = cs_q;
    assign mosi_out = mosi_q;
endmodule

// File: tb/tb_spi_cmd_tx.sv
// tb_spi_cmd_tx: directed vectors and corner sequences for the SPI command transmitter.
module tb_spi_cmd_tx;
    logic        clk = 1'b0, rst = 1'b1, tx_valid = 1'b0, tx_allow = 1'b1;
    logic [7:0]  cmd_in = '0;
    logic [44:0] payload_in = '0;
    logic        tx_ready, busy, done, sck_out, cs_out, mosi_out;
    int total = 0, passed = 0;

    always #5 clk = ~clk;

    spi_cmd_tx dut (
        .clk(clk), .rst(rst), .cmd_in(cmd_in), .payload_in(payload_in),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_allow(tx_allow),
        .busy(busy), .done(done), .sck_out(sck_out), .cs_out(cs_out), .mosi_out(mosi_out)
    );

    // receiver-side model, sampled on the falling clk edge
    logic        sck_p = 1'b0, cs_p = 1'b1, allow_p = 1'b1, mosi_p = 1'b0;
    int          cyc = 0, rises = 0, last_rises = 0, nfr = 0, fall_cnt = 0, done_cnt = 0;
    int          t_fall = 0, t_first = 0, t_last = 0, t_rise = 0, t_done = 0;
    int          gate_err = 0, mosi_err = 0;
    logic [52:0] cap = '0;
    logic [52:0] hist [0:31];

    always @(negedge clk) begin
        cyc     <= cyc + 1;
        sck_p   <= sck_out;
        cs_p    <= cs_out;
        allow_p <= tx_allow;
        mosi_p  <= mosi_out;
        if (done) begin
            done_cnt <= done_cnt + 1;
            t_done   <= cyc;
        end
        if (cs_p && !cs_out) begin
            fall_cnt <= fall_cnt + 1;
            t_fall   <= cyc;
            rises    <= 0;
            cap      <= '0;
        end else if (!cs_out && !sck_p && sck_out) begin
            if (rises < 53) cap[rises] <= mosi_out;
            if (rises == 0) t_first <= cyc;
            rises  <= rises + 1;
            t_last <= cyc;
            if (!allow_p) gate_err <= gate_err + 1;
        end
        if (!cs_p && !cs_out && mosi_out != mosi_p && !(sck_p && !sck_out)) mosi_err <= mosi_err + 1;
        if (!cs_p && cs_out) begin
            t_rise     <= cyc;
            last_rises <= rises;
            if (rises == 53 && nfr < 32) begin
                hist[nfr] <= cap;
                nfr       <= nfr + 1;
            end
        end
    end

    logic gate_en = 1'b0;
    int   gcnt = 0;
    initial forever begin
        @(posedge clk);
        #1;
        if (gate_en) begin
            gcnt     = (gcnt == 239) ? 0 : gcnt + 1;
            tx_allow = gcnt < 40;
        end else begin
            gcnt     = 0;
            tx_allow = 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c, input logic [44:0] p);
        int n = 0;
        logic r;
        cmd_in = c;
        payload_in = p;
        tx_valid = 1'b1;
        do begin
            r = tx_ready;
            @(posedge clk);
            n++;
        end while (!r && n < 2000);
        #1;
        chk("accepted", {63'd0, r}, 64'd1);
    endtask

    task automatic wait_done(input int lim);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < lim) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("done_seen", {63'd0, done_cnt != d0}, 64'd1);
    endtask

    function automatic logic [44:0] pk(input logic [5:0] c, input logic [6:0] x0, input logic [5:0] y0,
                                       input logic [6:0] x1, input logic [5:0] y1,
                                       input logic [6:0] x2, input logic [5:0] y2);
        return {y2, y1, y0, x2, x1, x0, c};
    endfunction

    typedef struct {
        logic [7:0]  cmd;
        logic [44:0] pl;
        logic [52:0] exp;
    } vec_t;
    vec_t v [5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, d0, fc0, tf1, tf2, n;
        logic seen;
        v[0] = '{8'h80, pk(6'h2A, 7'd10, 6'd5, 7'd100, 6'd40, 7'd60, 6'd59), 53'h1DD02BCC82AA80};
        v[1] = '{8'h01, 45'h0, 53'h01};
        v[2] = '{8'h42, {45{1'b1}}, 53'h1FFFFFFFFFFF42};
        v[3] = '{8'h81, 45'h0AAAAAAAAAAA, 53'h0AAAAAAAAAAA81};
        v[4] = '{8'h40, 45'h155555555555, 53'h15555555555540};

        tick(3);
        chk("rst_cs", {63'd0, cs_out}, 64'd1);
        chk("rst_sck", {63'd0, sck_out}, 64'd0);
        chk("rst_mosi", {63'd0, mosi_out}, 64'd0);
        chk("rst_ready", {63'd0, tx_ready}, 64'd1);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        rst = 1'b0;
        tick(2);

        for (int i = 0; i < 5; i++) begin
            f0 = nfr;
            d0 = done_cnt;
            send(v[i].cmd, v[i].pl);
            tx_valid = 1'b0;
            tick(1);
            chk($sformatf("v%0d_busy", i), {63'd0, busy}, 64'd1);
            wait_done(1000);
            tick(6);
            chk($sformatf("v%0d_frame", i), {11'd0, hist[f0]}, {11'd0, v[i].exp});
            chk($sformatf("v%0d_rises", i), 64'(last_rises), 64'd53);
            chk($sformatf("v%0d_setup", i), 64'(t_first - t_fall), 64'd8);
            chk($sformatf("v%0d_hold", i), 64'(t_rise - t_last), 64'd10);
            chk($sformatf("v%0d_done_once", i), 64'(done_cnt - d0), 64'd1);
            chk($sformatf("v%0d_done_at_cs", i), 64'(t_done), 64'(t_rise));
            chk($sformatf("v%0d_mosi_stable", i), 64'(mosi_err), 64'd0);
            chk($sformatf("v%0d_ready", i), {63'd0, tx_ready}, 64'd1);
        end

        // gated load window
        f0 = nfr;
        gate_en = 1'b1;
        send(8'h82, 45'h123456789AB);
        tx_valid = 1'b0;
        wait_done(20000);
        gate_en = 1'b0;
        tick(6);
        chk("gated_frame", {11'd0, hist[f0]}, 64'h123456789AB82);
        chk("gated_rises", 64'(last_rises), 64'd53);
        chk("gated_no_rise_when_low", 64'(gate_err), 64'd0);
        chk("gated_stretched", {63'd0, (t_rise - t_fall) > 500}, 64'd1);

        // back-to-back with tx_valid held
        f0 = nfr;
        send(8'h81, 45'hABC);
        cmd_in = 8'h41;
        payload_in = '0;
        tick(1);
        tf1 = t_fall;
        send(8'h41, 45'h0);
        tx_valid = 1'b0;
        tick(1);
        tf2 = t_fall;
        chk("b2b_gap", 64'(tf2 - t_rise), 64'd5);
        chk("b2b_period", 64'(tf2 - tf1), 64'd439);
        wait_done(1000);
        tick(6);
        chk("b2b_frame1", {11'd0, hist[f0]}, 64'hABC81);
        chk("b2b_frame2", {11'd0, hist[f0 + 1]}, 64'h41);

        // reset in the middle of a frame
        send(8'h80, 45'h1F);
        tx_valid = 1'b0;
        n = 0;
        while (rises < 20 && n < 2000) begin
            tick(1);
            n++;
        end
        chk("rst_mid_reached_rise20", {63'd0, rises >= 20}, 64'd1);
        d0 = done_cnt;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst_mid_cs", {63'd0, cs_out}, 64'd1);
        chk("rst_mid_sck", {63'd0, sck_out}, 64'd0);
        chk("rst_mid_ready", {63'd0, tx_ready}, 64'd1);
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        tick(30);
        chk("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
        f0 = nfr;
        send(8'h82, 45'h0F0F0F0F0F0);
        tx_valid = 1'b0;
        wait_done(1000);
        tick(6);
        chk("rst_mid_next_frame", {11'd0, hist[f0]}, 64'h0F0F0F0F0F082);

        // tx_valid pulsed while busy is ignored
        f0 = nfr;
        fc0 = fall_cnt;
        send(8'h80, 45'h3);
        tx_valid = 1'b0;
        tick(50);
        cmd_in = 8'h40;
        tx_valid = 1'b1;
        seen = 1'b0;
        repeat (3) begin
            if (tx_ready) seen = 1'b1;
            tick(1);
        end
        tx_valid = 1'b0;
        chk("busy_ready_low", {63'd0, seen}, 64'd0);
        wait_done(1000);
        chk("busy_ready_low_at_done", {63'd0, tx_ready}, 64'd0);
        tick(30);
        chk("busy_one_frame", 64'(fall_cnt - fc0), 64'd1);
        chk("busy_frame", {11'd0, hist[f0]}, 64'h380);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
